ula_sequencial: RTL and testbench
=================================

// Module: ula_sequencial
// PURPOSE
//  Execution ULA fed directly by ula_control: consumes its 4-bit operation code plus operands,
//  produces result and zero flag. Logic/arith ops finish in 1 cycle; variable shifts iterate
//  1 bit/cycle. start/busy/done handshake lets the datapath stall on shifts.
// PARAMETERS
//  WIDTH  32  operand/result width; power of 2, >= 8; shift amount = low $clog2(WIDTH) bits of a
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      asynchronous, active-low reset
//  start         in   1      request; accepted only when busy=0
//  operation     in   4      code from ula_control, sampled at accept
//  a             in   WIDTH  rs operand; shift amount for 1110/1111
//  b             in   WIDTH  rt/immediate operand; value shifted for 1110/1111/1011
//  arith_shift   in   1      1111 only: 1=SRAV (sign fill), 0=SRLV (zero fill)
//  unsigned_cmp  in   1      0111 only: 1=SLTU, 0=SLT
//  busy          out  1      1 while an accepted op is in progress
//  done          out  1      1-cycle pulse: result/zero valid
//  result        out  WIDTH  registered; holds value until next done
//  zero          out  1      registered; (result==0), updated with result
// BEHAVIOUR
//  Ops: 0000 a&b | 0001 a|b | 0010 a+b | 0110 a-b | 0111 set-less-than (1/0) | 1100 ~(a|b)
//   | 1101 a^b | 0011 pass a (jr) | 1011 b<<(WIDTH/2) (lui) | 1110 b<<n | 1111 b>>n
//   | any other code: result=0, normal 1-cycle completion.
//  Add/sub: modulo 2^WIDTH, carry/overflow discarded. SLT signed two's complement; SLTU unsigned.
//  Operands, operation, arith_shift, unsigned_cmp latched at accept; later input changes ignored.
//  FSM: IDLE -> (start & non-shift) -> DONE; IDLE -> (start & shift) -> SHIFT; SHIFT -> DONE
//   when remaining count==0; DONE -> IDLE.
//   IDLE: busy=0. SHIFT/DONE: busy=1. done=1 only in the DONE cycle, result/zero valid there.
//   SHIFT: holds b and counter n=a[$clog2(WIDTH)-1:0]; each cycle shifts 1 bit, n decrements.
//  Latency (accept edge -> done high): non-shift 1 cycle; shift n+1 cycles (n=0 -> 1 cycle,
//   result=b). busy rises the cycle after accept; throughput = 1 op per latency+1 cycles.
//  start while busy=1: ignored, not queued. start held high: new accept in first IDLE cycle.
//  SRAV fills with latched b[WIDTH-1]; n=WIDTH-1 on negative b gives all-ones.
//  Reset (any state, incl. mid-shift): state=IDLE, busy=0, done=0, result=0, zero=1; any
//   in-flight op is discarded with no done pulse.
// CONFIGURATION
//  ULA_FAST_SHIFT_EN defined: 1110/1111 computed by combinational barrel shifter; SHIFT state
//   unused, all ops 1-cycle latency.
//  Not defined: iterative 1-bit/cycle shifter as above (smaller area).
//  Results identical in both builds; only latency differs.
// TESTING
//  1 reset_n=0 mid-shift (n=20, cycle 5) -> busy=0, done=0, result=0, zero=1; no later done
//  2 op=0010 a=7 b=0xFFFFFFF9 -> done after 1 cycle, result=0, zero=1; op=0110 a=5 b=9 -> 0xFFFFFFFC
//  3 op=0111 a=0xFFFFFFFF b=1: unsigned_cmp=0 -> result=1; unsigned_cmp=1 -> result=0
//  4 op=1111 arith_shift=1 a=4 b=0x80000000 -> done exactly 5 cycles after accept, result 0xF8000000;
//    arith_shift=0 -> 0x08000000; with ULA_FAST_SHIFT_EN done after 1 cycle, same values
//  5 op=1110 a=0 b=0x1234 -> done after 1 cycle, result=0x1234; op=1011 b=0x1234 -> 0x12340000
//  6 start held while busy during n=31 shift, operands changed -> ignored, result from latched
//    values; next op accepted the cycle after done; op=1010 -> result=0, zero=1

Source files
------------

// File: rtl/ula_sequencial.sv
// Sequential ULA: 1-cycle logic/arith ops, iterative 1-bit/cycle variable shifts (ULA_FAST_SHIFT_EN: barrel shifter, all ops 1 cycle).
// Latency accept->done: 1 cycle; shifts n+1 cycles. Backpressure: start ignored (not queued) while busy=1.
module ula_sequencial #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith_shift,
  input  logic             unsigned_cmp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_val;
  logic [SW-1:0]    sh_cnt;
  logic             sh_left;
  logic             sh_arith;

  logic [SW-1:0]    n_in;
  logic             is_shift;
  logic             go_shift;
  logic             lt;
  logic [WIDTH-1:0] comb_res;
  logic [WIDTH-1:0] sh_next;

  assign n_in     = a[SW-1:0];
  assign is_shift = (operation == 4'b1110) || (operation == 4'b1111);
  assign lt       = unsigned_cmp ? (a < b) : ($signed(a) < $signed(b));

`ifdef ULA_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  // Zero-distance shifts complete immediately through the single-cycle path.
  assign go_shift = is_shift && (n_in != '0);
`endif

  always_comb begin
    comb_res = '0;
    case (operation)
      4'b0000: comb_res = a & b;
      4'b0001: comb_res = a | b;
      4'b0010: comb_res = a + b;
      4'b0110: comb_res = a - b;
      4'b0111: comb_res = {{(WIDTH-1){1'b0}}, lt};
      4'b1100: comb_res = ~(a | b);
      4'b1101: comb_res = a ^ b;
      4'b0011: comb_res = a;
      4'b1011: comb_res = b << (WIDTH/2);
`ifdef ULA_FAST_SHIFT_EN
      4'b1110: comb_res = b << n_in;
      4'b1111: comb_res = arith_shift ? WIDTH'($signed(b) >>> n_in) : (b >> n_in);
`else
      4'b1110: comb_res = b;
      4'b1111: comb_res = b;
`endif
      default: comb_res = '0;
    endcase
  end

  always_comb begin
    sh_next = '0;
    if (sh_left)
      sh_next = {sh_val[WIDTH-2:0], 1'b0};
    else
      sh_next = {sh_arith & sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      sh_val   <= '0;
      sh_cnt   <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (go_shift) begin
              state    <= SHIFT;
              sh_val   <= b;
              sh_cnt   <= n_in;
              sh_left  <= ~operation[0];
              sh_arith <= arith_shift;
            end else begin
              state  <= DONE;
              result <= comb_res;
              zero   <= (comb_res == '0);
              done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // The last shift step writes straight into result so done lands n cycles after accept.
          if (sh_cnt == SW'(1)) begin
            state  <= DONE;
            result <= sh_next;
            zero   <= (sh_next == '0);
            done   <= 1'b1;
          end else begin
            sh_val <= sh_next;
            sh_cnt <= sh_cnt - SW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Randomized self-checking bench for ula_sequencial against an arithmetic reference model.
module tb_ula_sequencial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  operation = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        arith_shift = 1'b0;
  logic        unsigned_cmp = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int tests = 0;
  int fails = 0;

  ula_sequencial #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .operation(operation),
    .a(a), .b(b), .arith_shift(arith_shift), .unsigned_cmp(unsigned_cmp),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                        input logic ar, input logic uns);
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint unsigned pw = 1;
    longint unsigned m = 64'd4294967296;
    int n = int'(x % 32);
    for (int i = 0; i < n; i++) pw = pw * 2;
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return 32'((ux + uy) % m);
      4'b0110: return 32'((ux + m - uy) % m);
      4'b0111: begin
        if (uns) return (ux < uy) ? 32'd1 : 32'd0;
        return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      end
      4'b1100: return ~(x | y);
      4'b1101: return x ^ y;
      4'b0011: return x;
      4'b1011: return 32'((uy * 65536) % m);
      4'b1110: return 32'((uy * pw) % m);
      4'b1111: begin
        if (ar && y[31]) return ~32'((~uy & 64'hFFFF_FFFF) / pw);
        return 32'(uy / pw);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] x);
`ifdef ULA_FAST_SHIFT_EN
    return 1;
`else
    if (op == 4'b1110 || op == 4'b1111) return int'(x % 32) + 1;
    return 1;
`endif
  endfunction

  // Waits for IDLE, issues one op, returns result/zero and cycles from accept to done (999 = timeout).
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic ar, input logic uns,
                        output logic [31:0] res, output logic zr, output int lat);
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clock); #1;
    end
    operation = op; a = x; b = y; arith_shift = ar; unsigned_cmp = uns; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; operation = 4'($urandom); arith_shift = ~ar; unsigned_cmp = ~uns;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) lat = 999;
    res = result;
    zr = zero;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic ar, input logic uns);
    logic [31:0] res, exp;
    logic        zr;
    int          lat, elat;
    exp  = model(op, x, y, ar, uns);
    elat = model_lat(op, x);
    run_op(op, x, y, ar, uns, res, zr, lat);
    tests++;
    if (res !== exp || zr !== (exp == 0) || lat != elat) begin
      fails++;
      $display("FAIL %s op=%b a=%h b=%h: got result=%h zero=%b lat=%0d, expected result=%h zero=%b lat=%0d",
               name, op, x, y, res, zr, lat, exp, (exp == 0), elat);
    end
  endtask

  task automatic test_reset;
    int seen;
    reset_n = 1'b0;
    #12;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b result=%h zero=%b, expected 0 0 0 1", busy, done, result, zero);
    end
    @(posedge clock); #3;
    reset_n = 1'b1;
    // Load a nonzero result, then reset mid-way through a 20-bit shift.
    check_op("pre_reset_or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0);
    @(posedge clock); #1;
    operation = 4'b1110; a = 32'd20; b = 32'h0000_0001; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #2;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      fails++;
      $display("FAIL reset_midshift: busy=%b done=%b result=%h zero=%b, expected 0 0 0 1", busy, done, result, zero);
    end
    #4;
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen != 0 || result !== 32'd0) begin
      fails++;
      $display("FAIL reset_no_done: busy/done cycles=%0d result=%h, expected 0 and 0", seen, result);
    end
  endtask

  task automatic test_arith;
    logic [3:0] ops[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101, 4'b0011, 4'b1011};
    check_op("add_wrap", 4'b0010, 32'd7, 32'hFFFF_FFF9, 1'b0, 1'b0);
    check_op("sub_neg", 4'b0110, 32'd5, 32'd9, 1'b0, 1'b0);
    check_op("lui", 4'b1011, $urandom, 32'h0000_1234, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      check_op("arith_rand", ops[i % 8], $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  task automatic test_slt;
    check_op("slt_signed", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_op("slt_unsigned", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++)
      check_op("slt_rand", 4'b0111, $urandom, $urandom, 1'b0, 1'($urandom));
  endtask

  task automatic test_shift;
    check_op("srav", 4'b1111, 32'd4, 32'h8000_0000, 1'b1, 1'b0);
    check_op("srlv", 4'b1111, 32'd4, 32'h8000_0000, 1'b0, 1'b0);
    check_op("sllv_zero", 4'b1110, 32'd0, 32'h0000_1234, 1'b0, 1'b0);
    check_op("srav_full", 4'b1111, 32'd31, 32'h8765_4321, 1'b1, 1'b0);
    check_op("sllv_31", 4'b1110, 32'd31, 32'h0000_0003, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      check_op("shift_rand", {3'b111, 1'($urandom)}, $urandom, $urandom, 1'($urandom), 1'b0);
    for (int i = 0; i < 8; i++)
      check_op("other_rand", 4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back;
    int lat, gap, elat;
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clock); #1; end
    operation = 4'b1110; a = 32'd31; b = 32'h0000_0001; arith_shift = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    // Keep start high and scramble operands while the op runs.
    operation = 4'b1010; a = 32'h0000_0005; b = 32'hFFFF_FFFF;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
    elat = model_lat(4'b1110, 32'd31);
    tests++;
    if (result !== 32'h8000_0000 || lat != elat) begin
      fails++;
      $display("FAIL b2b_latched: got result=%h lat=%0d, expected result=80000000 lat=%0d", result, lat, elat);
    end
    gap = 0;
    do begin @(posedge clock); #1; gap++; end while (!done && gap < 100);
    start = 1'b0;
    tests++;
    if (gap != 2 || result !== 32'd0 || zero !== 1'b1) begin
      fails++;
      $display("FAIL b2b_next: got gap=%0d result=%h zero=%b, expected gap=2 result=0 zero=1", gap, result, zero);
    end
    @(posedge clock); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got done=%b after one cycle, expected 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt();
    test_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
